// File: rtl/uart_rx_fsm_pkg.sv
// Shared UART definitions: frame data width, receiver state encoding and the
// even-parity convention used by both the transmitter and the receiver.
package uart_rx_fsm_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } rx_state_t;

    // Parity bit as emitted by the transmitter: XOR of all data bits.
    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Host-side receive interface: received byte, status flags and acknowledge.
interface uart_rx_fsm_if;
    import uart_rx_fsm_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_rdy;
    logic              par_err;
    logic              frm_err;
    logic              ovr_err;
    logic              rx_ack;

    modport master (
        output rx_data, rx_rdy, par_err, frm_err, ovr_err,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_rdy, par_err, frm_err, ovr_err,
        output rx_ack
    );

endinterface

// File: rtl/uart_rx_fsm_sync.sv
// Two-flop RXD synchronizer plus a majority vote over the current synced
// sample and the two synced samples taken on the preceding oversample ticks.
module uart_rx_fsm_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic rxd,
    output logic rxd_sync,
    output logic vote
);

    logic [1:0] meta;
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 2'b11;
            hist <= 2'b11;
        end else begin
            meta <= {meta[0], rxd};
            if (ce) begin
                hist <= {hist[0], meta[1]};
            end
        end
    end

    assign rxd_sync = meta[1];
    assign vote     = (hist[1] & hist[0]) | (hist[1] & rxd_sync) | (hist[0] & rxd_sync);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: start/8 data LSB-first/even parity/stop frames recovered with
// OVS-times oversampling, presented on a ready/acknowledge interface.
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int OVS = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx_ce,
    input  logic           rxd,
    uart_rx_fsm_if.master  bus
);

    localparam int            TW     = $clog2(OVS);
    localparam logic [TW-1:0] CENTRE = TW'(OVS / 2);

    rx_state_t         state;
    logic [TW-1:0]     tcnt;
    logic [2:0]        bcnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              rxd_sync;
    logic              vote;
    logic              centre;
    logic              done;

    uart_rx_fsm_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (rx_ce),
        .rxd      (rxd),
        .rxd_sync (rxd_sync),
        .vote     (vote)
    );

    assign centre = rx_ce && (tcnt == CENTRE);
    assign done   = centre && (state == ST_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            bus.rx_data <= '0;
            bus.rx_rdy  <= 1'b0;
            bus.par_err <= 1'b0;
            bus.frm_err <= 1'b0;
            bus.ovr_err <= 1'b0;
        end else begin
            if (rx_ce) begin
                tcnt <= tcnt + TW'(1);
                unique case (state)
                    ST_IDLE: begin
                        if (!rxd_sync) begin
                            state <= ST_START;
                            tcnt  <= '0;
                        end
                    end
                    ST_START: begin
                        if (centre) begin
                            if (vote) begin
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_DATA;
                                bcnt  <= '0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (centre) begin
                            shreg <= {vote, shreg[DATA_W-1:1]};
                            bcnt  <= bcnt + 3'd1;
                            if (bcnt == 3'd7) begin
                                state <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (centre) begin
                            par_bit <= vote;
                            state   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // A low stop bit parks in BRK so a held-low line is not
                        // mistaken for a fresh start bit.
                        if (centre) begin
                            state <= vote ? ST_IDLE : ST_BRK;
                        end
                    end
                    ST_BRK: begin
                        if (rxd_sync) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (done) begin
                bus.rx_data <= shreg;
                bus.par_err <= parity_of(shreg) ^ par_bit;
                bus.frm_err <= ~vote;
                bus.rx_rdy  <= 1'b1;
                if (bus.rx_rdy && !bus.rx_ack) begin
                    bus.ovr_err <= 1'b1;
                end
            end else if (bus.rx_ack) begin
                bus.rx_rdy  <= 1'b0;
                bus.ovr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: table of clean/parity/framing frames plus
// hand-written sequences for glitch, break, overrun, coincident ack and reset.
module tb_uart_rx_fsm;

    localparam int OVS     = 16;
    localparam int CE_DIV  = 4;
    localparam int BIT_CLK = OVS * CE_DIV;
    localparam int WAIT_MAX = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;
    logic rx_ce;
    int   cyc   = 0;

    int n_chk  = 0;
    int n_fail = 0;
    int lat    = 0;
    int k      = 0;

    uart_rx_fsm_if bus ();

    uart_rx_fsm #(.OVS(OVS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_ce (rx_ce),
        .rxd   (rxd),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rx_ce = (cyc % CE_DIV) == (CE_DIV - 1);

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] d, input logic rdy,
                               input logic pe, input logic fe, input logic ovr);
        chk({tag, ".rx_data"}, 32'(bus.rx_data), 32'(d));
        chk({tag, ".rx_rdy"},  32'(bus.rx_rdy),  32'(rdy));
        chk({tag, ".par_err"}, 32'(bus.par_err), 32'(pe));
        chk({tag, ".frm_err"}, 32'(bus.frm_err), 32'(fe));
        chk({tag, ".ovr_err"}, 32'(bus.ovr_err), 32'(ovr));
    endtask

    task automatic drive_bit(input logic v, input int periods);
        rxd = v;
        repeat (periods * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int stop_len);
        drive_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 1);
        drive_bit(p, 1);
        drive_bit(s, stop_len);
        rxd = 1'b1;
    endtask

    task automatic align();
        @(negedge clk);
        while ((cyc % CE_DIV) != 0) @(negedge clk);
    endtask

    task automatic wait_rdy(output int cnt);
        cnt = 0;
        while (!bus.rx_rdy && cnt < WAIT_MAX) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1};

        bus.rx_ack = 1'b0;
        repeat (5) @(negedge clk);
        check_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            align();
            fork
                send_frame(vt[i].d, vt[i].p, vt[i].s, 1);
                wait_rdy(k);
            join
            chk($sformatf("vec%0d.timeout", i), 32'(k < WAIT_MAX), 32'd1);
            if (i == 0) lat = k;
            check_state($sformatf("vec%0d", i), vt[i].d, 1'b1, vt[i].exp_pe, vt[i].exp_fe, 1'b0);
            ack_pulse();
            chk($sformatf("vec%0d.ack_clears_rdy", i), 32'(bus.rx_rdy), 32'd0);
            repeat (BIT_CLK) @(negedge clk);
        end
        // start recognised 4 clocks after the edge, then 168 ticks of 4 clocks
        chk("latency", 32'(lat >= 672 && lat <= 680), 32'd1);

        // 4-tick low glitch on the idle line
        align();
        rxd = 1'b0;
        repeat (4 * CE_DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        check_state("glitch", 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);

        // low stop bit with the line held low for three bit periods
        align();
        fork
            send_frame(8'h3C, 1'b0, 1'b0, 3);
            begin
                wait_rdy(k);
                check_state("break", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
                ack_pulse();
            end
        join
        repeat (12 * BIT_CLK) @(negedge clk);
        chk("break.no_second_byte", 32'(bus.rx_rdy), 32'd0);
        align();
        send_frame(8'h96, 1'b0, 1'b1, 1);
        check_state("after_break", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        ack_pulse();

        // back-to-back without acknowledge
        align();
        send_frame(8'h11, 1'b0, 1'b1, 1);
        align();
        send_frame(8'h22, 1'b0, 1'b1, 1);
        check_state("overrun", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        ack_pulse();
        chk("overrun.ack_rdy", 32'(bus.rx_rdy), 32'd0);
        chk("overrun.ack_ovr", 32'(bus.ovr_err), 32'd0);

        // acknowledge on exactly the completion edge of the next byte
        align();
        send_frame(8'h33, 1'b0, 1'b1, 1);
        align();
        fork
            send_frame(8'h44, 1'b0, 1'b1, 1);
            begin
                repeat (lat - 1) @(negedge clk);
                chk("coinc.before", 32'(bus.rx_data), 32'h33);
                bus.rx_ack = 1'b1;
                @(negedge clk);
                bus.rx_ack = 1'b0;
                check_state("coinc", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
            end
        join

        // unacknowledged byte forces an overrun, then reset mid-frame
        align();
        send_frame(8'h55, 1'b0, 1'b1, 1);
        check_state("pre_reset", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        align();
        drive_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1);
        repeat (BIT_CLK / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_state("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        align();
        fork
            send_frame(8'h5A, 1'b0, 1'b1, 1);
            wait_rdy(k);
        join
        chk("post_reset.timeout", 32'(k < WAIT_MAX), 32'd1);
        check_state("post_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

UART receiver: recovers 8N-with-parity frames (start, 8 data LSB-first, even parity, 1 stop) from the serial line and presents each byte on a ready/acknowledge interface. It is the counterpart of the UART transmit FSM, sharing its frame format and parity convention (parity bit = XOR of the 8 data bits). It oversamples the line using a clock-enable from the shared UART baud generator and sits between the RXD pin and the host-side receive register.

## Interface
- OVS, 16: oversampling ticks per bit; power of two, 8 to 32.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RX_CE  in  1  one-CLK-wide oversample tick, OVS per bit period.
- RXD  in  1  serial line, asynchronous, idle high.
- RX_ACK  in  1  consumer has taken RX_DATA; level, sampled every CLK.
- RX_DATA  out  8  last received byte; reset 8'h00.
- RX_RDY  out  1  RX_DATA valid and unread; reset 0.
- PAR_ERR  out  1  parity error of the byte in RX_DATA; reset 0.
- FRM_ERR  out  1  stop bit sampled low for the byte in RX_DATA; reset 0.
- OVR_ERR  out  1  a byte was overwritten before RX_ACK; sticky; reset 0.

## Operation
- RXD passes through a 2-flop synchronizer (reset value 1) before all use; all state advance happens only on CLK edges with RX_CE=1.
- Tick counter TCNT (log2(OVS) bits) counts RX_CE ticks within a bit; bit counter BCNT (3 bits) counts data bits.
- Bit value = majority of three synchronized samples taken at TCNT = OVS/2-2, OVS/2-1, OVS/2; decision at TCNT = OVS/2.
- States:
  - IDLE: on tick with synced RXD=0 -> START, TCNT=0.
  - START: at decision, vote=1 -> IDLE (glitch rejected); vote=0 -> DATA, BCNT=0. TCNT wraps OVS-1 -> 0 throughout.
  - DATA: vote at each bit centre, shifted in LSB-first; after BCNT=7 -> PARITY.
  - PARITY: vote stored as parity bit -> STOP.
  - STOP: at centre decision: load RX_DATA, PAR_ERR = XOR(data, parity bit), FRM_ERR = ~vote, set RX_RDY; vote=1 -> IDLE, vote=0 -> BRK.
  - BRK: wait for tick with synced RXD=1 -> IDLE (no new start detected while line held low).
- Handshake: RX_RDY cleared on any CLK with RX_ACK=1 and no completion that cycle. Completion and RX_ACK in the same cycle: new byte loaded, RX_RDY stays 1, OVR_ERR unchanged.
- Completion while RX_RDY=1 and RX_ACK=0: byte overwritten, OVR_ERR set; OVR_ERR cleared by RX_ACK only.
- RX_DATA/PAR_ERR/FRM_ERR change only at completion.
- RST_N low at any time, including mid-frame: all outputs and state to reset values immediately; partial frame discarded.

## Timing
- Synchronizer latency 2 CLK; start edge recognised on first RX_CE tick after synced RXD low.
- RX_RDY, RX_DATA and error flags update on the CLK edge of the stop-bit decision tick (mid-stop bit); IDLE re-entered the same edge, so a start bit immediately after the stop bit is caught.
- Frame-to-RX_RDY latency: 10*OVS + OVS/2 ticks after start-edge recognition, +/-1 tick.
- Tolerates baud mismatch up to ±3 % relative to transmitter.

## Structure
- Shared UART package: state encoding constants (IDLE, START, DATA, PARITY, STOP, BRK), data width 8, parity convention shared with the transmitter.
- One natural sub-module: uart_rx_sync (2-flop synchronizer plus 3-sample majority voter), reusable elsewhere.

## Test plan
- Byte 8'hA5, parity 0, stop 1, OVS=16 -> RX_DATA=8'hA5, RX_RDY=1, PAR_ERR=0, FRM_ERR=0; RX_ACK pulse clears RX_RDY.
- Byte 8'h01 sent with parity 0 (wrong) -> RX_DATA=8'h01, PAR_ERR=1.
- Byte 8'h3C with stop bit 0, line held low 3 bit periods -> FRM_ERR=1, no second byte until line high then new start.
- Low glitch of 4 ticks on idle line -> returns to IDLE, RX_RDY stays 0.
- Back-to-back 8'h11, 8'h22 without RX_ACK -> RX_DATA=8'h22, OVR_ERR=1; RX_ACK clears RX_RDY and OVR_ERR; ACK coincident with completion -> RX_RDY=1, OVR_ERR=0.
- RST_N asserted during data bit 4 of 8'hFF -> all outputs 0 immediately; next clean frame 8'h5A received correctly.
